// File: rtl/encode_mod_rm.sv
// encode_mod_rm: serialises one addressing descriptor into ModR/M, optional SIB and displacement bytes.
module encode_mod_rm #(
  parameter bit FORCE_DISP32 = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_addr_32,
  input  logic        in_is_reg,
  input  logic [2:0]  in_reg,
  input  logic        in_base_valid,
  input  logic [2:0]  in_base,
  input  logic        in_index_valid,
  input  logic [2:0]  in_index,
  input  logic [1:0]  in_scale,
  input  logic [31:0] in_disp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        out_error
);
  typedef enum logic [2:0] {IDLE, MODRM, SIB, DISP, ERR} state_t;
  state_t state_q, state_d;
  logic [7:0] modrm_q, modrm_d, sib_q, sib_d;
  logic [31:0] disp_q, disp_d;
  logic has_sib_q, has_sib_d, has_disp_q, has_disp_d;
  logic [1:0] dlast_q, dlast_d, cnt_q, cnt_d;
  logic zero, d8ok, use_sib, bp_sp, abs_mem, illegal;
  logic [1:0] rule_mod, e_mod;
  logic [2:0] e_rm, rm16;
  always_comb begin
    zero = in_addr_32 ? in_disp == 32'd0 : in_disp[15:0] == 16'd0;
    d8ok = in_addr_32 ? (&in_disp[31:7] || ~|in_disp[31:7]) : (&in_disp[15:7] || ~|in_disp[15:7]);
    use_sib = in_addr_32 && (in_index_valid || (in_base_valid && in_base == 3'b100));
    // EBP/BP base with mod00 would mean "no base", so a zero disp still needs an explicit disp8
    bp_sp = in_base_valid && in_base == 3'b101 && (in_addr_32 || !in_index_valid);
    abs_mem = !in_base_valid && (in_addr_32 || !in_index_valid);
    rule_mod = zero ? {1'b0, bp_sp} : (d8ok && !FORCE_DISP32) ? 2'b01 : 2'b10;
    e_mod = in_is_reg ? 2'b11 : abs_mem ? 2'b00 : rule_mod;
    rm16 = abs_mem ? 3'b110 :
           (in_base_valid && in_index_valid) ? {1'b0, in_base == 3'b101, in_index[0]} :
           in_index_valid ? {2'b10, in_index[0]} : {2'b11, in_base != 3'b101};
    e_rm = in_is_reg ? in_base : !in_addr_32 ? rm16 : use_sib ? 3'b100 : abs_mem ? 3'b101 : in_base;
    illegal = !in_is_reg && (in_addr_32 ? (in_index_valid && in_index == 3'b100) :
              (in_scale != 2'b00 || (in_base_valid && in_base != 3'b011 && in_base != 3'b101) ||
               (in_index_valid && in_index[2:1] != 2'b11)));
  end
  always_comb begin
    state_d = state_q;
    modrm_d = modrm_q;
    sib_d = sib_q;
    disp_d = disp_q;
    has_sib_d = has_sib_q;
    has_disp_d = has_disp_q;
    dlast_d = dlast_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = illegal ? ERR : MODRM;
        modrm_d = {e_mod, in_reg, e_rm};
        sib_d = {in_scale, in_index_valid ? in_index : 3'b100, in_base_valid ? in_base : 3'b101};
        disp_d = in_disp;
        has_sib_d = use_sib && !in_is_reg;
        has_disp_d = !in_is_reg && (abs_mem || rule_mod != 2'b00);
        dlast_d = e_mod == 2'b01 ? 2'd0 : in_addr_32 ? 2'd3 : 2'd1;
        cnt_d = 2'd0;
      end
      MODRM: if (out_ready) state_d = has_sib_q ? SIB : has_disp_q ? DISP : IDLE;
      SIB: if (out_ready) state_d = has_disp_q ? DISP : IDLE;
      DISP: if (out_ready) begin
        state_d = cnt_q == dlast_q ? IDLE : DISP;
        cnt_d = cnt_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      modrm_q <= '0;
      sib_q <= '0;
      disp_q <= '0;
      has_sib_q <= 1'b0;
      has_disp_q <= 1'b0;
      dlast_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      modrm_q <= modrm_d;
      sib_q <= sib_d;
      disp_q <= disp_d;
      has_sib_q <= has_sib_d;
      has_disp_q <= has_disp_d;
      dlast_q <= dlast_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_error = state_q == ERR;
  assign out_valid = state_q == MODRM || state_q == SIB || state_q == DISP;
  assign out_byte = state_q == MODRM ? modrm_q : state_q == SIB ? sib_q :
                    state_q == DISP ? disp_q[8*cnt_q +: 8] : 8'h00;
  assign out_last = state_q == MODRM ? !has_sib_q && !has_disp_q :
                    state_q == SIB ? !has_disp_q : state_q == DISP && cnt_q == dlast_q;
endmodule

// File: tb/tb_encode_mod_rm.sv
// tb_encode_mod_rm: directed descriptors with hand-computed byte streams.
module tb_encode_mod_rm;
  logic clock = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, in_addr_32 = 1'b0, in_is_reg = 1'b0;
  logic [2:0] in_reg = '0, in_base = '0, in_index = '0;
  logic in_base_valid = 1'b0, in_index_valid = 1'b0;
  logic [1:0] in_scale = '0;
  logic [31:0] in_disp = '0;
  logic out_valid, out_ready = 1'b0, out_last, out_error;
  logic [7:0] out_byte;
  int checks = 0, errors = 0;
  encode_mod_rm dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr_32(in_addr_32), .in_is_reg(in_is_reg), .in_reg(in_reg),
    .in_base_valid(in_base_valid), .in_base(in_base), .in_index_valid(in_index_valid),
    .in_index(in_index), .in_scale(in_scale), .in_disp(in_disp), .out_valid(out_valid),
    .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last), .out_error(out_error)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic a32, input logic isr, input logic [2:0] r, input logic bv,
                       input logic [2:0] b, input logic iv, input logic [2:0] i,
                       input logic [1:0] sc, input logic [31:0] d);
    @(negedge clock);
    chk("in_ready_idle", in_ready, 1);
    in_addr_32 = a32; in_is_reg = isr; in_reg = r; in_base_valid = bv; in_base = b;
    in_index_valid = iv; in_index = i; in_scale = sc; in_disp = d; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask
  task automatic take(input string tag, input logic [39:0] e, input int n, input bit stall);
    for (int k = 0; k < n; k++) begin
      if (stall) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk({tag, "_stall_valid"}, out_valid, 1);
          chk({tag, "_stall_byte"}, out_byte, e[8*k +: 8]);
          chk({tag, "_stall_rdy"}, in_ready, 0);
          @(negedge clock);
        end
      end
      out_ready = 1'b1;
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_byte"}, out_byte, e[8*k +: 8]);
      chk({tag, "_last"}, out_last, k == n - 1);
      chk({tag, "_err"}, out_error, 0);
      @(negedge clock);
      out_ready = 1'b0;
    end
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_rdy"}, in_ready, 1);
  endtask
  initial begin
    repeat (2) @(negedge clock);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_last", out_last, 0);
    chk("rst_error", out_error, 0);
    reset = 1'b0;
    issue(1, 0, 3'b000, 1, 3'b011, 1, 3'b110, 2'b11, 32'h20);
    take("sib", 40'h20F344, 3, 0);
    issue(0, 0, 3'b000, 1, 3'b011, 1, 3'b110, 2'b00, 32'h0006);
    take("bxsi", 40'h0640, 2, 0);
    issue(1, 0, 3'b000, 1, 3'b101, 0, 3'b000, 2'b00, 32'h0);
    take("ebp", 40'h0045, 2, 0);
    issue(1, 0, 3'b000, 1, 3'b100, 0, 3'b000, 2'b00, 32'h0);
    take("esp", 40'h2404, 2, 0);
    issue(1, 0, 3'b000, 0, 3'b000, 0, 3'b000, 2'b00, 32'h12345678);
    take("abs32", 40'h1234567805, 5, 0);
    issue(0, 0, 3'b000, 1, 3'b101, 0, 3'b000, 2'b00, 32'h0);
    take("bp16", 40'h0046, 2, 0);
    issue(0, 1, 3'b001, 1, 3'b010, 0, 3'b000, 2'b00, 32'h0);
    take("regdir", 40'hCA, 1, 0);
    issue(1, 0, 3'b010, 1, 3'b000, 0, 3'b000, 2'b00, 32'h100);
    take("disp32", 40'h0000010090, 5, 0);
    issue(0, 0, 3'b000, 0, 3'b000, 1, 3'b110, 2'b00, 32'h0000FFFE);
    take("si_neg", 40'hFE44, 2, 0);
    issue(1, 0, 3'b000, 1, 3'b011, 1, 3'b110, 2'b11, 32'h20);
    take("stall", 40'h20F344, 3, 1);
    issue(0, 0, 3'b000, 1, 3'b000, 0, 3'b000, 2'b00, 32'h0);
    chk("ill_error", out_error, 1);
    chk("ill_valid", out_valid, 0);
    chk("ill_rdy", in_ready, 0);
    @(negedge clock);
    chk("ill_error_off", out_error, 0);
    chk("ill_valid_off", out_valid, 0);
    chk("ill_rdy_back", in_ready, 1);
    issue(1, 0, 3'b000, 1, 3'b011, 1, 3'b100, 2'b00, 32'h0);
    chk("esp_idx_error", out_error, 1);
    @(negedge clock);
    issue(1, 0, 3'b000, 0, 3'b000, 0, 3'b000, 2'b00, 32'h12345678);
    out_ready = 1'b1;
    chk("rst_mid_b0", out_byte, 8'h05);
    @(negedge clock);
    chk("rst_mid_b1", out_byte, 8'h78);
    @(negedge clock);
    out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_rdy", in_ready, 1);
    chk("rst_mid_last", out_last, 0);
    @(negedge clock);
    chk("rst_mid_stay", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
